alu_rs: RTL and testbench
=========================

# alu_rs

ALU reservation station sitting between instruction decode (issue side) and the ROB result ports. Holds up to DEPTH pending ALU instructions, snoops the ROB broadcast snapshot to resolve operand tags, dispatches one ready instruction per cycle into an internal single-cycle ALU, and drives the tagged result onto the ROB's ALU target/result port. It is the consumer end of the ROB broadcast and the producer end of the ALU result interface.

## Interface
- DEPTH, 4, number of station entries
- ROB_N, 16, ROB entries; tags 0..ROB_N-1 are entry indices
- TAG_W, 5, tag width
- TAG_INVALID, 5'h1F, "no tag" / operand-present / no-result value
- DATA_W, 32, operand and result width
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-low.
- flush  in  1  branch/jump recovery: drop all entries
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  station can accept; high when at least one entry is free
- issue_op  in  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9; 10-15 reserved, result 0
- issue_qj, issue_qk  in  TAG_W  source tags; TAG_INVALID means value already in vj/vk
- issue_vj, issue_vk  in  DATA_W  source values, meaningful when matching q is TAG_INVALID
- issue_dest  in  TAG_W  ROB tag of this instruction
- bc_valid  in  ROB_N  ROB entry valid, bit i = entry i
- bc_ready  in  ROB_N  ROB entry result ready
- bc_val  in  ROB_N*DATA_W  entry i value in bits [i*DATA_W +: DATA_W]
- out_target  out  TAG_W  ROB tag being completed, TAG_INVALID when idle
- out_result  out  DATA_W  ALU result for out_target

## Operation
- Per entry: busy, op, qj, vj, qk, vk, dest.
- Accept: issue_valid && issue_ready && !flush. Writes lowest-index non-busy entry.
- Issue-time capture: if issue_qj != TAG_INVALID and bc_valid[qj] && bc_ready[qj], store qj=TAG_INVALID, vj=bc_val slice. Same for k.
- Wakeup: each edge, for each busy entry with qj != TAG_INVALID and bc_valid[qj] && bc_ready[qj], set vj from bc_val and qj to TAG_INVALID. Same for k. Wakeup and dispatch of the same entry never happen in one edge: dispatch sees registered q only.
- Dispatch: candidate = lowest-index busy entry with qj == qk == TAG_INVALID. At the edge, compute the ALU result and register it into out_result; register dest into out_target; clear busy. With no candidate, out_target <= TAG_INVALID and out_result holds.
- ALU, mod 2^DATA_W:
  - ADD/SUB: wraparound.
  - SLL/SRL/SRA: shift amount vk[4:0]; SRA sign-fills.
  - SLT: signed compare, result 1 or 0.
  - SLTU: unsigned compare, result 1 or 0.
- issue_ready = !(all busy), computed from registered busy bits only. A slot freed by dispatch in a given cycle does not raise issue_ready until the next cycle.
- The freed slot and the accepted slot in one edge are always different entries, since accept only targets entries already non-busy.
- flush (rst high): all busy <= 0, out_target <= TAG_INVALID. Issue and dispatch are suppressed that edge.

## Timing
- Reset (rst low at edge): busy all 0, out_target = TAG_INVALID, out_result = 0. issue_ready = 1 the following cycle. Reset mid-operation discards all entries and any in-flight result.
- Latency, operands present at issue: accept at edge N, dispatch at edge N+1, out_target/out_result valid from N+1 for exactly one cycle.
- Latency, operand tag becomes ready in the broadcast before edge M: wakeup at M, dispatch at M+1.
- Throughput: one dispatch per cycle. out_target is a one-cycle pulse per instruction; back-to-back dispatches produce consecutive distinct tags.
- Full: with DEPTH entries busy, issue_ready = 0 and issue_valid is ignored. Decode holds the instruction.
- A broadcast for a tag with bc_valid=0 is never captured, even if bc_ready=1.

## Test plan
- Reset then issue ADD qj=qk=1F vj=5 vk=7 dest=3 at edge 1 -> out_target=3, out_result=12 after edge 2; out_target=1F after edge 3.
- Issue SUB qj=2 vk=1 (qk=1F) dest=4. Hold bc_ready[2]=0 for 3 cycles, then bc_valid[2]=bc_ready[2]=1 with val 10 -> out_target=4, out_result=9 exactly 2 edges after bc_ready rises. No output before then.
- Fill 4 entries, all waiting on tag 7 -> issue_ready=0 and a 5th issue is ignored. Release tag 7 -> dispatch tags in entry order 0,1,2,3 on consecutive cycles; issue_ready=1 from the cycle after the first dispatch.
- SRA vj=32'h8000_0000 vk=32'h24 -> 32'hF800_0000. SLT vj=32'hFFFF_FFFF vk=1 -> 1. SLTU on the same operands -> 0. ADD 32'hFFFF_FFFF+1 -> 0.
- Two entries busy, assert flush together with issue_valid -> no result pulse that edge or after, the issued instruction is dropped, and issue_ready=1.
- Drive rst low for one edge while an entry is mid-dispatch -> out_target=1F, out_result=0. No stale completion appears afterwards.

Source files
------------

// File: rtl/alu_rs_if.sv
// ALU reservation station bus bundle.
// Carries the decode issue handshake, the ROB broadcast snapshot and the
// tagged ALU result towards the ROB.
//   master : decode/ROB side (drives issue_* and bc_*, receives the result)
//   slave  : reservation station (receives issue_* and bc_*, drives the result)
interface alu_rs_if #(
  parameter int unsigned ROB_N  = 16,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
);
  logic                    issue_valid;
  logic                    issue_ready;
  logic [3:0]              issue_op;
  logic [TAG_W-1:0]        issue_qj;
  logic [TAG_W-1:0]        issue_qk;
  logic [DATA_W-1:0]       issue_vj;
  logic [DATA_W-1:0]       issue_vk;
  logic [TAG_W-1:0]        issue_dest;
  logic [ROB_N-1:0]        bc_valid;
  logic [ROB_N-1:0]        bc_ready;
  logic [ROB_N*DATA_W-1:0] bc_val;
  logic [TAG_W-1:0]        out_target;
  logic [DATA_W-1:0]       out_result;

  modport master (
    output issue_valid, issue_op, issue_qj, issue_qk, issue_vj, issue_vk,
           issue_dest, bc_valid, bc_ready, bc_val,
    input  issue_ready, out_target, out_result
  );

  modport slave (
    input  issue_valid, issue_op, issue_qj, issue_qk, issue_vj, issue_vk,
           issue_dest, bc_valid, bc_ready, bc_val,
    output issue_ready, out_target, out_result
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station.
// Buffers up to DEPTH ALU instructions, resolves operand tags from the ROB
// broadcast snapshot, dispatches the lowest-index ready entry each cycle
// through a single-cycle ALU and registers the tagged result.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset
//   flush : drop every entry and any pending result
//   bus   : issue handshake, ROB broadcast in, out_target/out_result out
module alu_rs #(
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      ROB_N       = 16,
  parameter int unsigned      TAG_W       = 5,
  parameter logic [TAG_W-1:0] TAG_INVALID = '1,
  parameter int unsigned      DATA_W      = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_rs_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [3:0]        op_q   [DEPTH];
  logic [3:0]        op_d   [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qj_d   [DEPTH];
  logic [TAG_W-1:0]  qk_q   [DEPTH];
  logic [TAG_W-1:0]  qk_d   [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vj_d   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [DATA_W-1:0] vk_d   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [TAG_W-1:0]  out_target_q, out_target_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;

  logic             issue_ready;
  logic             accept;
  logic             free_found, cand_found;
  logic [IDX_W-1:0] free_idx, cand_idx;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [4:0]        shamt;

  // Tags outside 0..ROB_N-1 (including TAG_INVALID) never match an entry.
  function automatic logic tag_hit(input logic [TAG_W-1:0] t,
                                   input logic [ROB_N-1:0] v,
                                   input logic [ROB_N-1:0] r);
    tag_hit = 1'b0;
    for (int unsigned i = 0; i < ROB_N; i++)
      if (t == TAG_W'(i)) tag_hit = v[i] & r[i];
  endfunction

  function automatic logic [DATA_W-1:0] tag_val(input logic [TAG_W-1:0] t,
                                                input logic [ROB_N*DATA_W-1:0] vals);
    tag_val = '0;
    for (int unsigned i = 0; i < ROB_N; i++)
      if (t == TAG_W'(i)) tag_val = vals[i*DATA_W +: DATA_W];
  endfunction

  // Ready is derived from registered busy bits only, so a slot freed by
  // this cycle's dispatch is not offered until the next cycle.
  assign issue_ready = ~&busy_q;
  assign accept      = bus.issue_valid && issue_ready && !flush;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (!busy_q[e] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(e);
      end
      if (busy_q[e] && qj_q[e] == TAG_INVALID && qk_q[e] == TAG_INVALID && !cand_found) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(e);
      end
    end
  end

  always_comb begin
    alu_a = vj_q[cand_idx];
    alu_b = vk_q[cand_idx];
    shamt = alu_b[4:0];
    case (op_e'(op_q[cand_idx]))
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SLL:  alu_res = alu_a << shamt;
      OP_SRL:  alu_res = alu_a >> shamt;
      OP_SRA:  alu_res = $signed(alu_a) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    busy_d       = busy_q;
    out_target_d = TAG_INVALID;
    out_result_d = out_result_q;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      op_d[e]   = op_q[e];
      qj_d[e]   = qj_q[e];
      qk_d[e]   = qk_q[e];
      vj_d[e]   = vj_q[e];
      vk_d[e]   = vk_q[e];
      dest_d[e] = dest_q[e];
    end

    if (flush) begin
      busy_d = '0;
    end else begin
      // Wakeup only touches q/v; dispatch below already chose from the
      // registered q values, so a woken entry waits one more edge.
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (busy_q[e]) begin
          if (qj_q[e] != TAG_INVALID && tag_hit(qj_q[e], bus.bc_valid, bus.bc_ready)) begin
            qj_d[e] = TAG_INVALID;
            vj_d[e] = tag_val(qj_q[e], bus.bc_val);
          end
          if (qk_q[e] != TAG_INVALID && tag_hit(qk_q[e], bus.bc_valid, bus.bc_ready)) begin
            qk_d[e] = TAG_INVALID;
            vk_d[e] = tag_val(qk_q[e], bus.bc_val);
          end
        end
      end

      if (cand_found) begin
        busy_d[cand_idx] = 1'b0;
        out_target_d     = dest_q[cand_idx];
        out_result_d     = alu_res;
      end

      if (accept) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (free_idx == IDX_W'(e)) begin
            busy_d[e] = 1'b1;
            op_d[e]   = bus.issue_op;
            dest_d[e] = bus.issue_dest;
            qj_d[e]   = bus.issue_qj;
            vj_d[e]   = bus.issue_vj;
            qk_d[e]   = bus.issue_qk;
            vk_d[e]   = bus.issue_vk;
            if (bus.issue_qj != TAG_INVALID && tag_hit(bus.issue_qj, bus.bc_valid, bus.bc_ready)) begin
              qj_d[e] = TAG_INVALID;
              vj_d[e] = tag_val(bus.issue_qj, bus.bc_val);
            end
            if (bus.issue_qk != TAG_INVALID && tag_hit(bus.issue_qk, bus.bc_valid, bus.bc_ready)) begin
              qk_d[e] = TAG_INVALID;
              vk_d[e] = tag_val(bus.issue_qk, bus.bc_val);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q       <= '0;
      out_target_q <= TAG_INVALID;
      out_result_q <= '0;
    end else begin
      busy_q       <= busy_d;
      out_target_q <= out_target_d;
      out_result_q <= out_result_d;
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      op_q[e]   <= op_d[e];
      qj_q[e]   <= qj_d[e];
      qk_q[e]   <= qk_d[e];
      vj_q[e]   <= vj_d[e];
      vk_q[e]   <= vk_d[e];
      dest_q[e] <= dest_d[e];
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.out_target  = out_target_q;
  assign bus.out_result  = out_result_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ROB_N  = 16;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [4:0]  INV    = 5'h1F;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  alu_rs_if #(.ROB_N(ROB_N), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  alu_rs #(
    .DEPTH(DEPTH),
    .ROB_N(ROB_N),
    .TAG_W(TAG_W),
    .TAG_INVALID(INV),
    .DATA_W(DATA_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] qj, input logic [31:0] vj,
                       input logic [4:0] qk, input logic [31:0] vk, input logic [4:0] dest);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_qj    = qj;
    bus.issue_vj    = vj;
    bus.issue_qk    = qk;
    bus.issue_vk    = vk;
    bus.issue_dest  = dest;
  endtask

  task automatic bc_set(input int t, input logic v, input logic r, input logic [31:0] val);
    bus.bc_valid[t]          = v;
    bus.bc_ready[t]          = r;
    bus.bc_val[t*32 +: 32]   = val;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{4'd0,  32'd5,          32'd7,          5'd3,  32'd12};
    vecs[1]  = '{4'd1,  32'd3,          32'd5,          5'd4,  32'hFFFF_FFFE};
    vecs[2]  = '{4'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  5'd5,  32'h00F0_1200};
    vecs[3]  = '{4'd3,  32'hF000_0001,  32'h0000_0F00,  5'd6,  32'hF000_0F01};
    vecs[4]  = '{4'd4,  32'hAAAA_5555,  32'hFFFF_0000,  5'd7,  32'h5555_5555};
    vecs[5]  = '{4'd5,  32'h0000_0001,  32'h0000_003F,  5'd8,  32'h8000_0000};
    vecs[6]  = '{4'd6,  32'h8000_0000,  32'h0000_0004,  5'd9,  32'h0800_0000};
    vecs[7]  = '{4'd7,  32'h8000_0000,  32'h0000_0024,  5'd10, 32'hF800_0000};
    vecs[8]  = '{4'd8,  32'hFFFF_FFFF,  32'h0000_0001,  5'd11, 32'd1};
    vecs[9]  = '{4'd9,  32'hFFFF_FFFF,  32'h0000_0001,  5'd12, 32'd0};
    vecs[10] = '{4'd0,  32'hFFFF_FFFF,  32'h0000_0001,  5'd13, 32'd0};
    vecs[11] = '{4'd12, 32'd9,          32'd9,          5'd14, 32'd0};
    vecs[12] = '{4'd8,  32'h0000_0001,  32'hFFFF_FFFF,  5'd15, 32'd0};
    vecs[13] = '{4'd9,  32'h0000_0001,  32'hFFFF_FFFF,  5'd0,  32'd1};
    vecs[14] = '{4'd7,  32'h7000_0000,  32'h0000_0004,  5'd1,  32'h0700_0000};

    rst   = 1'b0;
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_qj    = INV;
    bus.issue_qk    = INV;
    bus.issue_vj    = '0;
    bus.issue_vk    = '0;
    bus.issue_dest  = '0;
    bus.bc_valid    = '0;
    bus.bc_ready    = '0;
    bus.bc_val      = '0;

    // Reset state
    step();
    rst = 1'b1;
    chk("reset_target", 32'(bus.out_target), 32'(INV));
    chk("reset_result", bus.out_result, 32'd0);
    chk("reset_ready",  32'(bus.issue_ready), 32'd1);

    // ALU vectors, operands present at issue
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, INV, vecs[i].vj, INV, vecs[i].vk, vecs[i].dest);
      step();
      bus.issue_valid = 1'b0;
      chk($sformatf("vec%0d_idle", i), 32'(bus.out_target), 32'(INV));
      step();
      chk($sformatf("vec%0d_target", i), 32'(bus.out_target), 32'(vecs[i].dest));
      chk($sformatf("vec%0d_result", i), bus.out_result, vecs[i].exp);
    end
    step();
    chk("vec_last_pulse_end", 32'(bus.out_target), 32'(INV));

    // Wakeup through broadcast
    issue(4'd1, 5'd2, 32'hDEAD_BEEF, INV, 32'd1, 5'd4);
    step();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wake_hold%0d", i), 32'(bus.out_target), 32'(INV));
    end
    bc_set(2, 1'b0, 1'b1, 32'd77);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("wake_novalid%0d", i), 32'(bus.out_target), 32'(INV));
    end
    bc_set(2, 1'b1, 1'b1, 32'd10);
    step();
    chk("wake_edge_m", 32'(bus.out_target), 32'(INV));
    step();
    chk("wake_target", 32'(bus.out_target), 32'd4);
    chk("wake_result", bus.out_result, 32'd9);
    bc_set(2, 1'b0, 1'b0, 32'd0);
    step();
    chk("wake_pulse_end", 32'(bus.out_target), 32'(INV));

    // Capture at issue time
    bc_set(3, 1'b1, 1'b1, 32'd40);
    issue(4'd0, 5'd3, 32'd0, INV, 32'd2, 5'd2);
    step();
    bus.issue_valid = 1'b0;
    bc_set(3, 1'b0, 1'b0, 32'd0);
    chk("capture_idle", 32'(bus.out_target), 32'(INV));
    step();
    chk("capture_target", 32'(bus.out_target), 32'd2);
    chk("capture_result", bus.out_result, 32'd42);

    // Fill all entries waiting on tag 7
    for (int i = 0; i < 4; i++) begin
      issue(4'd0, 5'd7, 32'd0, INV, 32'(i), 5'(8 + i));
      step();
    end
    bus.issue_valid = 1'b0;
    chk("full_ready_low", 32'(bus.issue_ready), 32'd0);
    issue(4'd0, INV, 32'd1, INV, 32'd1, 5'd12);
    step();
    bus.issue_valid = 1'b0;
    chk("full_ignore_ready", 32'(bus.issue_ready), 32'd0);
    chk("full_ignore_idle", 32'(bus.out_target), 32'(INV));
    bc_set(7, 1'b1, 1'b1, 32'd100);
    step();
    chk("full_wake_idle", 32'(bus.out_target), 32'(INV));
    chk("full_wake_ready", 32'(bus.issue_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("full_disp%0d_target", i), 32'(bus.out_target), 32'(8 + i));
      chk($sformatf("full_disp%0d_result", i), bus.out_result, 32'(100 + i));
      chk($sformatf("full_disp%0d_ready", i), 32'(bus.issue_ready), 32'd1);
    end
    bc_set(7, 1'b0, 1'b0, 32'd0);
    step();
    chk("full_drained", 32'(bus.out_target), 32'(INV));

    // Flush with two waiting entries and a concurrent issue
    issue(4'd0, 5'd6, 32'd0, INV, 32'd1, 5'd13);
    step();
    issue(4'd0, 5'd6, 32'd0, INV, 32'd2, 5'd14);
    step();
    issue(4'd0, INV, 32'd3, INV, 32'd4, 5'd15);
    bc_set(6, 1'b1, 1'b1, 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    chk("flush_target", 32'(bus.out_target), 32'(INV));
    chk("flush_ready",  32'(bus.issue_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_after%0d", i), 32'(bus.out_target), 32'(INV));
    end
    bc_set(6, 1'b0, 1'b0, 32'd0);

    // Reset while an entry is about to dispatch
    issue(4'd0, INV, 32'd1, INV, 32'd2, 5'd5);
    step();
    bus.issue_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_mid_target", 32'(bus.out_target), 32'(INV));
    chk("rst_mid_result", bus.out_result, 32'd0);
    step();
    chk("rst_mid_after0", 32'(bus.out_target), 32'(INV));
    step();
    chk("rst_mid_after1", 32'(bus.out_target), 32'(INV));
    chk("rst_mid_ready",  32'(bus.issue_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
